// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    localparam int DEF_W = 8;
    localparam int DEF_A = 8;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-by-byte memory copy engine sharing the data memory port with the core;
// the core owns the port whenever the engine is not in READ or WRITE.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int A = DEF_A
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    input  logic [A-1:0] CpuAddr,
    input  logic         CpuWriteEn,
    input  logic [W-1:0] CpuDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic [A-1:0] MemAddr,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataIn,
    output logic         Busy,
    output logic         Done
);

    copy_state_t  state;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A-1:0] len;
    logic [A-1:0] idx;
    logic [W-1:0] buffer;
    logic [A-1:0] idx_nxt;

    assign idx_nxt = idx + A'(1);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            idx    <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src   <= SrcAddr;
                        dst   <= DstAddr;
                        len   <= Len;
                        idx   <= '0;
                        state <= (Len != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    buffer <= MemDataOut;
                    state  <= WRITE;
                end
                WRITE: begin
                    idx   <= idx_nxt;
                    state <= (idx_nxt == len) ? DONE : READ;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux: engine drives memory only while busy, otherwise the core passes straight through.
    always_comb begin
        MemAddr    = CpuAddr;
        MemWriteEn = CpuWriteEn;
        MemDataIn  = CpuDataIn;
        case (state)
            READ: begin
                MemAddr    = src + idx;
                MemWriteEn = 1'b0;
                MemDataIn  = buffer;
            end
            WRITE: begin
                MemAddr    = dst + idx;
                MemWriteEn = 1'b1;
                MemDataIn  = buffer;
            end
            default: ;
        endcase
    end

    assign Busy = (state == READ) || (state == WRITE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural data memory on its port.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr, DstAddr, Len;
    logic [7:0] CpuAddr;
    logic       CpuWriteEn;
    logic [7:0] CpuDataIn;
    logic [7:0] MemDataOut;
    logic [7:0] MemAddr;
    logic       MemWriteEn;
    logic [7:0] MemDataIn;
    logic       Busy;
    logic       Done;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.W(8), .A(8)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .CpuAddr    (CpuAddr),
        .CpuWriteEn (CpuWriteEn),
        .CpuDataIn  (CpuDataIn),
        .MemDataOut (MemDataOut),
        .MemAddr    (MemAddr),
        .MemWriteEn (MemWriteEn),
        .MemDataIn  (MemDataIn),
        .Busy       (Busy),
        .Done       (Done)
    );

    always @(posedge clk) begin
        if (MemWriteEn) mem[MemAddr] <= MemDataIn;
    end
    assign MemDataOut = mem[MemAddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        CpuAddr    = a;
        CpuDataIn  = d;
        CpuWriteEn = 1'b1;
        tick();
        CpuWriteEn = 1'b0;
    endtask

    // Issue Start, then observe a bounded window of cycles after the accepting edge.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int win, input int restart_at,
                            output int done_cyc, output int n_done,
                            output int n_busy, output int n_wr);
        SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1;
        tick();
        Start = 1'b0;
        done_cyc = -1; n_done = 0; n_busy = 0; n_wr = 0;
        for (int c = 1; c <= win; c++) begin
            if (c == restart_at) begin
                SrcAddr = 8'h40; DstAddr = 8'hA0; Len = 8'd1; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (Busy) n_busy++;
            if (MemWriteEn) n_wr++;
            tick();
        end
        Start = 1'b0;
    endtask

    initial begin
        int dc, nd, nb, nw;
        Reset = 1'b1; Start = 1'b0;
        SrcAddr = '0; DstAddr = '0; Len = '0;
        CpuAddr = '0; CpuWriteEn = 1'b0; CpuDataIn = '0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state and idle pass-through
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        CpuAddr = 8'h55; CpuDataIn = 8'h77; CpuWriteEn = 1'b1;
        #1;
        check("idle_addr", MemAddr, 8'h55);
        check("idle_we", MemWriteEn, 1);
        check("idle_data", MemDataIn, 8'h77);
        CpuWriteEn = 1'b0;
        tick();

        // Basic 4-byte copy
        cpu_write(8'h10, 8'hAA); cpu_write(8'h11, 8'hBB);
        cpu_write(8'h12, 8'hCC); cpu_write(8'h13, 8'hDD);
        cpu_write(8'h84, 8'h00);
        run_copy(8'h10, 8'h80, 8'd4, 12, 0, dc, nd, nb, nw);
        check("basic_done_cyc", dc, 9);
        check("basic_n_done", nd, 1);
        check("basic_busy", nb, 8);
        check("basic_writes", nw, 4);
        check("basic_m80", mem[8'h80], 8'hAA);
        check("basic_m81", mem[8'h81], 8'hBB);
        check("basic_m82", mem[8'h82], 8'hCC);
        check("basic_m83", mem[8'h83], 8'hDD);
        check("basic_m84", mem[8'h84], 8'h00);

        // Zero-length request
        run_copy(8'h10, 8'h80, 8'd0, 4, 0, dc, nd, nb, nw);
        check("zero_done_cyc", dc, 1);
        check("zero_n_done", nd, 1);
        check("zero_busy", nb, 0);
        check("zero_writes", nw, 0);

        // Address wrap on both source and destination side
        cpu_write(8'hFE, 8'h01); cpu_write(8'hFF, 8'h02);
        cpu_write(8'h00, 8'h03); cpu_write(8'h01, 8'h04);
        run_copy(8'hFE, 8'h02, 8'd4, 12, 0, dc, nd, nb, nw);
        check("wrap_m02", mem[8'h02], 8'h01);
        check("wrap_m03", mem[8'h03], 8'h02);
        check("wrap_m04", mem[8'h04], 8'h03);
        check("wrap_m05", mem[8'h05], 8'h04);
        check("wrap_writes", nw, 4);

        // Overlapping forward copy propagates the first byte
        cpu_write(8'h20, 8'h05); cpu_write(8'h21, 8'h00);
        cpu_write(8'h22, 8'h00); cpu_write(8'h23, 8'h00);
        cpu_write(8'h24, 8'h09);
        run_copy(8'h20, 8'h21, 8'd3, 10, 0, dc, nd, nb, nw);
        check("ovl_m21", mem[8'h21], 8'h05);
        check("ovl_m22", mem[8'h22], 8'h05);
        check("ovl_m23", mem[8'h23], 8'h05);
        check("ovl_m24", mem[8'h24], 8'h09);
        check("ovl_done_cyc", dc, 7);

        // Start during a copy is ignored
        cpu_write(8'h30, 8'h11); cpu_write(8'h31, 8'h22);
        cpu_write(8'h40, 8'h33); cpu_write(8'hA0, 8'hEE);
        run_copy(8'h30, 8'h90, 8'd2, 8, 3, dc, nd, nb, nw);
        check("ign_n_done", nd, 1);
        check("ign_done_cyc", dc, 5);
        check("ign_writes", nw, 2);
        check("ign_m90", mem[8'h90], 8'h11);
        check("ign_m91", mem[8'h91], 8'h22);
        check("ign_mA0", mem[8'hA0], 8'hEE);

        // Reset during the third WRITE of an 8-byte copy, with Start also high
        for (int k = 0; k < 8; k++) begin
            cpu_write(8'h50 + 8'(k), 8'h61 + 8'(k));
            cpu_write(8'hB0 + 8'(k), 8'h00);
        end
        SrcAddr = 8'h50; DstAddr = 8'hB0; Len = 8'd8; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("abort_in_write", {31'd0, MemWriteEn}, 1);
        check("abort_addr", MemAddr, 8'hB2);
        Reset = 1'b1; Start = 1'b1;
        tick();
        Reset = 1'b0; Start = 1'b0;
        CpuAddr = 8'hC0; CpuDataIn = 8'h5A; CpuWriteEn = 1'b1;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_pass_we", MemWriteEn, 1);
        check("abort_pass_addr", MemAddr, 8'hC0);
        CpuWriteEn = 1'b0;
        nd = 0; nb = 0;
        for (int c = 0; c < 6; c++) begin
            if (Done) nd++;
            if (Busy) nb++;
            tick();
        end
        check("abort_no_done", nd, 0);
        check("abort_no_busy", nb, 0);
        check("abort_mB0", mem[8'hB0], 8'h61);
        check("abort_mB1", mem[8'hB1], 8'h62);
        check("abort_mB2_ok", (mem[8'hB2] == 8'h63) || (mem[8'hB2] == 8'h00), 1);
        for (int k = 3; k < 8; k++) check("abort_tail", mem[8'hB0 + 8'(k)], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter W, default 8: data width, matching the data memory entry width.
REQ-002 SHALL have parameter A, default 8: address width, giving a 2**A-entry memory.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 SHALL have port SrcAddr  input  A  first source address, captured on accepted Start.
REQ-007 SHALL have port DstAddr  input  A  first destination address, captured on accepted Start.
REQ-008 SHALL have port Len  input  A  byte count, captured on accepted Start; 0 means no transfer.
REQ-009 SHALL have port CpuAddr  input  A  core-side address, passed through when idle.
REQ-010 SHALL have port CpuWriteEn  input  1  core-side write enable, passed through when idle.
REQ-011 SHALL have port CpuDataIn  input  W  core-side write data, passed through when idle.
REQ-012 SHALL have port MemDataOut  input  W  combinational read data returned by the data memory.
REQ-013 SHALL have port MemAddr  output  A  address driven to the data memory.
REQ-014 SHALL have port MemWriteEn  output  1  write enable driven to the data memory.
REQ-015 SHALL have port MemDataIn  output  W  write data driven to the data memory.
REQ-016 SHALL have port Busy  output  1  high while the engine owns the memory port in READ or WRITE; the core stalls on it.
REQ-017 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 In IDLE with Start=1: SHALL capture Src, Dst and Len, clear index i, and go to READ if Len!=0, else DONE.
REQ-020 In READ: MemAddr=Src+i, MemWriteEn=0, MemDataOut latched into a W-bit buffer at the cycle end; next state WRITE.
REQ-021 In WRITE: MemAddr=Dst+i, MemWriteEn=1, MemDataIn=buffer, i increments; next state DONE if i+1==Len, else READ.
REQ-022 In DONE: Done=1 for exactly one cycle, memory outputs as in IDLE; next state IDLE.
REQ-023 In IDLE and DONE: MemAddr=CpuAddr, MemWriteEn=CpuWriteEn, MemDataIn=CpuDataIn (combinational pass-through).
REQ-024 In READ and WRITE: SHALL ignore core inputs entirely; Busy=1.
REQ-025 Address arithmetic SHALL be modulo 2**A, so Src+i and Dst+i wrap from 2**A-1 to 0.
REQ-026 Latency: for Len=N>0, Start accepted at edge k puts Done high in cycle k+2N+1; for Len=0, Done is high in cycle k+1.
REQ-027 A Start arriving outside IDLE SHALL be ignored, with no queuing.
REQ-028 Overlapping ranges SHALL use strict ascending byte-by-byte semantics (read i, then write i); no overlap detection.
REQ-029 Outputs SHALL depend only on state, registers and pass-through inputs, with no combinational path from Start to Mem*.

Reset
REQ-030 When Reset=1 at a posedge: state=IDLE, i=0, Src=Dst=Len=0, buffer=0; Busy=0 and Done=0 thereafter.
REQ-031 Reset mid-copy SHALL abort immediately with no Done pulse; bytes already written stay written and no further writes occur.
REQ-032 Reset SHALL take priority over Start in the same cycle.

Structure
REQ-033 Shared package mem_copy_pkg SHALL hold the state enum typedef (IDLE, READ, WRITE, DONE) and default W/A constants.
REQ-034 The design SHALL have no sub-module; the port mux and FSM are inline, and the block instantiates alongside the data memory at top level.

Verification
REQ-035 Preload mem[0x10..0x13]=AA,BB,CC,DD; Start Src=0x10 Dst=0x80 Len=4 -> mem[0x80..0x83]=AA,BB,CC,DD; Busy high for 8 cycles; Done in cycle 9.
REQ-036 Start Len=0 -> no MemWriteEn, Busy never high, Done one cycle after Start.
REQ-037 Src=0xFE Dst=0x02 Len=4, mem[FE,FF,00,01]=1,2,3,4 -> mem[02..05]=1,2,3,4, verifying address wrap.
REQ-038 Overlap Src=0x20 Dst=0x21 Len=3, mem[0x20]=5 -> mem[0x21..0x23]=5,5,5.
REQ-039 Second Start mid-copy -> ignored; only the first copy completes, with one Done.
REQ-040 Reset asserted in the 3rd WRITE of a Len=8 copy -> exactly 2 or 3 bytes written, no Done, IDLE pass-through of CpuWriteEn on the next cycle.
